div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Multi-cycle RV32M divider and its sequencing FSM, shared by the ex stage.
//   - Accepts DIV/DIVU/REM/REMU operands from ex.
//   - Iterates one quotient bit per cycle (restoring division).
//   - Drives busy_o, which feeds ex.div_busy_i to suppress rd writeback while a division is in flight.
//   - Returns the result with a one-cycle ready_o pulse plus the destination register tag.
// PARAMETERS
//   DATA_W      32  operand/result width (XLEN)
//   REG_ADDR_W  5   destination register address width
// PORTS
//   clk         in   1           clock; all state updates on rising edge
//   rst         in   1           synchronous reset, active-high
//   start_i     in   1           request a division; sampled only in IDLE
//   funct3_i    in   3           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i  in   DATA_W      rs1 value
//   divisor_i   in   DATA_W      rs2 value
//   rd_i        in   REG_ADDR_W  destination register of the request
//   kill_i      in   1           abort (branch flush/hold from ctrl)
//   busy_o      out  1           division in flight (state CALC)
//   ready_o     out  1           one-cycle pulse: result_o/rd_o valid
//   result_o    out  DATA_W      quotient or remainder
//   rd_o        out  REG_ADDR_W  destination tag latched at start
// BEHAVIOUR
//   Reset: state=IDLE; busy_o=0, ready_o=0, result_o=0, rd_o=0; counter and internal regs cleared.
//     Applies in any state, including mid-CALC; the aborted operation produces no ready_o.
//   States: IDLE, CALC, DONE.
//   IDLE:
//     - start_i=1 and funct3_i[2]=1: latch operands, funct3 and rd.
//     - start_i with funct3_i[2]=0 is ignored.
//     - Signed ops (DIV, REM) take |operand|; record quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)).
//     - divisor==0, or signed with dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE, special-case result.
//     - Otherwise go to CALC with count=0.
//   CALC:
//     - busy_o=1.
//     - Per cycle: shift {rem,quot} left by 1, subtract divisor; if non-negative keep the result and set quot LSB.
//     - count increments; after DATA_W iterations (count==DATA_W-1) go to DONE.
//   DONE:
//     - busy_o=0, ready_o=1 for exactly this cycle.
//     - result_o and rd_o are registered on entry and stay stable until the next DONE.
//     - Next state is always IDLE.
//   Latency:
//     - Start sampled at edge T.
//     - Normal: CALC spans cycles T+1..T+DATA_W; ready_o at cycle T+DATA_W+1 (33 for DATA_W=32).
//     - Special cases: ready_o at cycle T+1, busy_o never asserted.
//   Result rules:
//     - DIV/DIVU: quotient truncated toward zero; negate if quotient sign set (signed only).
//     - REM/REMU: remainder negated if dividend negative (signed only).
//     - Divide by zero: quotient = all ones, remainder = dividend.
//     - Signed overflow: quotient = 0x80000000, remainder = 0.
//   Concurrency and abort:
//     - start_i while in CALC or DONE is ignored; the requester must wait for IDLE (busy_o=0, ready_o=0).
//     - kill_i=1 in any state: IDLE next cycle, busy_o=0, no ready_o pulse; result_o/rd_o keep their old values.
//     - kill_i and start_i together in IDLE: kill wins, request dropped.
//     - kill_i in DONE: the ready_o pulse already asserted this cycle stands; kill only forces the IDLE transition.
// TESTING
//   1. DIVU 100/7, rd=5 -> busy_o 1 for cycles 1..32; cycle 33 ready_o=1, result_o=14, rd_o=5. REMU -> 2.
//   2. DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD.
//   3. DIV 5/0 -> ready_o at cycle 1, result 0xFFFFFFFF, busy_o never 1; REMU 5/0 -> 5.
//   4. DIV 0x80000000/0xFFFFFFFF -> ready_o at cycle 1, result 0x80000000; REM -> 0.
//   5. kill_i at cycle 10 of CALC -> busy_o=0 at cycle 11, no ready_o; a new DIVU 9/3 then returns 3 after 33 cycles.
//   6. rst at cycle 20 of CALC -> all outputs 0 next cycle; start_i during CALC ignored (exactly one ready_o per accepted start).

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring, one quotient bit per cycle.
// Latency: DATA_W+1 cycles start->ready_o; divide-by-zero and signed overflow answer in 1.
// No backpressure: start_i is taken only in IDLE; kill_i aborts silently at any time.
module div_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [REG_ADDR_W-1:0] rd_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic                  op_rem;
        logic                  neg_q;
        logic                  neg_r;
        logic [REG_ADDR_W-1:0] rd;
    } ctx_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] dvsr_q;
    ctx_t              ctx_q;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic              div_zero;
    logic              ovf;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic [DATA_W-1:0] special_dat;

    assign is_signed   = ~funct3_i[0];
    assign a_neg       = is_signed & dividend_i[DATA_W-1];
    assign b_neg       = is_signed & divisor_i[DATA_W-1];
    assign a_abs       = a_neg ? -dividend_i : dividend_i;
    assign b_abs       = b_neg ? -divisor_i : divisor_i;
    assign div_zero    = (divisor_i == '0);
    assign ovf         = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign special_dat = div_zero ? (funct3_i[1] ? dividend_i : '1)
                                  : (funct3_i[1] ? '0 : MIN_NEG);

    // The partial remainder is below the divisor, so one extra bit holds the shifted value.
    logic [DATA_W:0]   shifted;
    logic              ge;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quot_nxt;
    logic [DATA_W-1:0] final_dat;

    assign shifted   = {rem_q, quot_q[DATA_W-1]};
    assign ge        = (shifted >= {1'b0, dvsr_q});
    assign rem_nxt   = ge ? (shifted[DATA_W-1:0] - dvsr_q) : shifted[DATA_W-1:0];
    assign quot_nxt  = {quot_q[DATA_W-2:0], ge};
    assign final_dat = ctx_q.op_rem ? (ctx_q.neg_r ? -rem_nxt : rem_nxt)
                                    : (ctx_q.neg_q ? -quot_nxt : quot_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            ctx_q    <= '0;
            busy_o   <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            ready_o <= 1'b0;
            if (kill_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i && funct3_i[2]) begin
                            ctx_q <= '{op_rem: funct3_i[1], neg_q: a_neg ^ b_neg,
                                       neg_r: a_neg, rd: rd_i};
                            if (div_zero || ovf) begin
                                state    <= DONE;
                                ready_o  <= 1'b1;
                                result_o <= special_dat;
                                rd_o     <= rd_i;
                            end else begin
                                state  <= CALC;
                                busy_o <= 1'b1;
                                count  <= '0;
                                rem_q  <= '0;
                                quot_q <= a_abs;
                                dvsr_q <= b_abs;
                            end
                        end
                    end
                    CALC: begin
                        rem_q  <= rem_nxt;
                        quot_q <= quot_nxt;
                        count  <= count + 1'b1;
                        // Last iteration's result is folded straight into the output register.
                        if (count == CNT_W'(DATA_W-1)) begin
                            state    <= DONE;
                            busy_o   <= 1'b0;
                            ready_o  <= 1'b1;
                            result_o <= final_dat;
                            rd_o     <= ctx_q.rd;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
